prog_mem_loader: RTL and testbench
==================================

PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8, program-counter width.
REQ-002 SHALL have parameter IR_WIDTH, default 16, instruction width; an integer multiple of 8.
REQ-003 SHALL have parameter CMD_CNT, default 64, number of instruction words; at most 2**PC_WIDTH.
REQ-004 SHALL have port clk  input  1  the one clock; all state changes on its rising edge.
REQ-005 SHALL have port res  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port pc  input  PC_WIDTH  read address.
REQ-007 SHALL have port rd_en  input  1  read request.
REQ-008 SHALL have port ir  output  IR_WIDTH  registered instruction word.
REQ-009 SHALL have port ir_valid  output  1  one-cycle pulse, ir valid.
REQ-010 SHALL have port ld_start  input  1  begin a program load at address 0.
REQ-011 SHALL have port ld_byte  input  8  load data byte.
REQ-012 SHALL have port ld_valid  input  1  ld_byte valid.
REQ-013 SHALL have port ld_ready  output  1  byte accepted when ld_valid and ld_ready are both 1.
REQ-014 SHALL have port ld_done  input  1  end-of-load strobe.
REQ-015 SHALL have port busy  output  1  high in CLEAR or LOAD.
REQ-016 SHALL have port ld_err  output  1  sticky load error.
REQ-017 SHALL have port par_err  output  1  read parity error pulse.

Function
REQ-018 SHALL implement FSM states CLEAR, RUN and LOAD.
REQ-019 CLEAR: SHALL write 0 to one address per cycle, 0 to CMD_CNT-1, then enter RUN; CMD_CNT cycles total.
REQ-020 RUN: rd_en=1 SHALL give ir=mem[pc] with ir_valid=1 exactly one cycle later (latency 1); ir SHALL hold its value otherwise.
REQ-021 pc >= CMD_CNT SHALL read as 0 (NOP), with ir_valid still pulsed.
REQ-022 rd_en in CLEAR or LOAD SHALL be ignored; ir_valid stays 0.
REQ-023 RUN with ld_start=1 SHALL enter LOAD, clear the load address and byte count, and clear ld_err; a read issued in the same cycle SHALL still complete.
REQ-024 ld_ready SHALL be 1 only in LOAD.
REQ-025 LOAD: accepted bytes SHALL assemble most-significant byte first; after IR_WIDTH/8 bytes the word SHALL be written to the load address in the same cycle, and the address SHALL increment.
REQ-026 Bytes accepted when the load address equals CMD_CNT SHALL be discarded and SHALL set ld_err; no wrap-around.
REQ-027 ld_done in LOAD SHALL return the FSM to RUN next cycle; a partially assembled word SHALL be discarded and SHALL set ld_err.
REQ-028 ld_done and a byte accepted in the same cycle: the byte SHALL be processed first, then done is applied.
REQ-029 ld_start outside RUN, and ld_done outside LOAD, SHALL be ignored.

Reset
REQ-030 res=1 SHALL immediately force state CLEAR, clear address/byte count, and set ir=0, ir_valid=0, ld_ready=0, ld_err=0, par_err=0, busy=1.
REQ-031 Reset during LOAD SHALL abandon the load; memory SHALL be re-cleared by CLEAR.

Configuration
REQ-032 With PROG_MEM_PARITY_EN defined, each word SHALL store an extra even-parity bit, written in CLEAR and LOAD.
REQ-033 With PROG_MEM_PARITY_EN defined, a read with a parity mismatch SHALL output ir=0 and pulse par_err together with ir_valid.
REQ-034 Without PROG_MEM_PARITY_EN, no parity storage SHALL exist and par_err SHALL be constant 0.

Verification
REQ-035 Release reset -> busy=1 for 64 cycles, then 0; reads of pc=0..63 all return 16'h0000 with ir_valid one cycle after rd_en.
REQ-036 ld_start; bytes 8'h49,8'h03,8'h4A,8'h14; ld_done -> mem[0]=16'h4903, mem[1]=16'h4A14, ld_err=0; rd_en at pc=1 gives ir=16'h4A14 next cycle.
REQ-037 Load 3 bytes 8'h12,8'h34,8'h56 then ld_done -> mem[0]=16'h1234, mem[1] unchanged 0, ld_err=1; next ld_start clears ld_err.
REQ-038 Load 130 bytes (65 words) -> words 0..63 written, last two bytes dropped, ld_err=1; rd_en at pc=8'd200 -> ir=0, ir_valid=1.
REQ-039 Assert res mid-LOAD after 2 words -> state CLEAR, all outputs at reset values, memory all zero after 64 cycles.
REQ-040 With PROG_MEM_PARITY_EN, flip the stored parity bit of word 5 via force; read pc=5 -> ir=0, par_err=1 and ir_valid=1 in the same cycle.

Source files
------------

// File: rtl/prog_mem_loader.sv
// ---------------------------------------------------------------------------
// prog_mem_loader
//   Program memory with a byte-serial loader. After reset the memory is
//   zeroed one word per cycle (CLEAR). It then serves registered reads (RUN).
//   On request it accepts a program as a byte stream, most-significant byte
//   first, and packs the bytes into words (LOAD).
//
//   Optional feature: define PROG_MEM_PARITY_EN to store an even-parity bit
//   with every word and to flag parity mismatches on reads.
//
// Ports
//   clk       clock; all state changes on its rising edge
//   res       asynchronous active-high reset
//   pc        read address
//   rd_en     read request (RUN only); ir/ir_valid follow one cycle later
//   ir        registered instruction word; holds its value between reads
//   ir_valid  one-cycle pulse marking a new ir
//   ld_start  start a load at address 0 (RUN only)
//   ld_byte   load data byte
//   ld_valid  ld_byte valid
//   ld_ready  high in LOAD; a byte is accepted when ld_valid && ld_ready
//   ld_done   end of load (LOAD only)
//   busy      high in CLEAR or LOAD
//   ld_err    sticky load error: overflow or partial final word
//   par_err   read parity error pulse; constant 0 without parity
// ---------------------------------------------------------------------------
module prog_mem_loader #(
   parameter int PC_WIDTH = 8,
   parameter int IR_WIDTH = 16,
   parameter int CMD_CNT  = 64
) (
   input  logic                clk,
   input  logic                res,
   input  logic [PC_WIDTH-1:0] pc,
   input  logic                rd_en,
   output logic [IR_WIDTH-1:0] ir,
   output logic                ir_valid,
   input  logic                ld_start,
   input  logic [7:0]          ld_byte,
   input  logic                ld_valid,
   output logic                ld_ready,
   input  logic                ld_done,
   output logic                busy,
   output logic                ld_err,
   output logic                par_err
);

   localparam int NB     = IR_WIDTH / 8;
   localparam int BC_W   = (NB > 1) ? $clog2(NB) : 1;
   // One extra bit so the load address can reach CMD_CNT (the "full" mark).
   localparam int AW     = PC_WIDTH + 1;
   localparam int MEM_AW = (CMD_CNT > 1) ? $clog2(CMD_CNT) : 1;
`ifdef PROG_MEM_PARITY_EN
   localparam int MW     = IR_WIDTH + 1;
`else
   localparam int MW     = IR_WIDTH;
`endif

   typedef enum logic [1:0] {CLEAR, RUN, LOAD} state_t;

   state_t              state;
   logic [AW-1:0]       addr;
   logic [BC_W-1:0]     byte_cnt;
   logic [IR_WIDTH-1:0] shift;
   logic [MW-1:0]       mem [CMD_CNT];

   logic                addr_full;
   logic                byte_take;
   logic                word_last;
   logic                partial_after;
   logic [IR_WIDTH-1:0] word_next;
   logic                we;
   logic [MEM_AW-1:0]   wa;
   logic [IR_WIDTH-1:0] wd;
   logic                pc_in_range;
   logic [MW-1:0]       rd_raw;
   logic                rd_bad;

   // Both are pure decodes of the state register, so they are glitch-free
   // and take their reset values as soon as res asserts.
   assign busy     = (state != RUN);
   assign ld_ready = (state == LOAD);

   assign addr_full = (addr == AW'(CMD_CNT));
   assign byte_take = (state == LOAD) && ld_valid && !addr_full;
   assign word_last = (byte_cnt == BC_W'(NB - 1));
   assign word_next = (shift << 8) | IR_WIDTH'(ld_byte);
   // Byte count as it stands after this cycle's byte. ld_done uses it so
   // that a byte arriving together with ld_done is counted first.
   assign partial_after = byte_take ? !word_last : (byte_cnt != '0);

   assign pc_in_range = ({1'b0, pc} < AW'(CMD_CNT));
   assign rd_raw      = mem[pc[MEM_AW-1:0]];
`ifdef PROG_MEM_PARITY_EN
   assign rd_bad = pc_in_range && (^rd_raw);
`else
   assign rd_bad = 1'b0;
   assign par_err = 1'b0;
`endif

   // NOTE: every signal gets a default at the top of the block; otherwise
   // paths that do not assign it would infer a latch.
   always_comb begin
      we = 1'b0;
      wa = addr[MEM_AW-1:0];
      wd = '0;
      if (state == CLEAR) begin
         we = 1'b1;
      end else if (byte_take && word_last) begin
         we = 1'b1;
         wd = word_next;
      end
   end

   // NOTE: the memory array has no reset. CLEAR zeroes it after every reset,
   // which keeps it mappable to RAM.
   always_ff @(posedge clk) begin
      if (we) begin
`ifdef PROG_MEM_PARITY_EN
         mem[wa] <= {^wd, wd};
`else
         mem[wa] <= wd;
`endif
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state    <= CLEAR;
         addr     <= '0;
         byte_cnt <= '0;
         shift    <= '0;
         ir       <= '0;
         ir_valid <= 1'b0;
         ld_err   <= 1'b0;
`ifdef PROG_MEM_PARITY_EN
         par_err  <= 1'b0;
`endif
      end else begin
         ir_valid <= 1'b0;
`ifdef PROG_MEM_PARITY_EN
         par_err  <= 1'b0;
`endif
         case (state)
            CLEAR: begin
               if (addr == AW'(CMD_CNT - 1)) begin
                  state <= RUN;
                  addr  <= '0;
               end else begin
                  addr <= addr + 1'b1;
               end
            end
            RUN: begin
               // A read issued together with ld_start still completes.
               if (rd_en) begin
                  ir_valid <= 1'b1;
                  ir       <= (pc_in_range && !rd_bad) ? rd_raw[IR_WIDTH-1:0] : '0;
`ifdef PROG_MEM_PARITY_EN
                  par_err  <= rd_bad;
`endif
               end
               if (ld_start) begin
                  state    <= LOAD;
                  addr     <= '0;
                  byte_cnt <= '0;
                  ld_err   <= 1'b0;
               end
            end
            LOAD: begin
               // Memory is full: bytes are dropped and flagged; no wrap.
               if (ld_valid && addr_full) ld_err <= 1'b1;
               if (byte_take) begin
                  shift <= word_next;
                  if (word_last) begin
                     byte_cnt <= '0;
                     addr     <= addr + 1'b1;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
               if (ld_done) begin
                  state <= RUN;
                  if (partial_after) ld_err <= 1'b1;
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_mem_loader
//   Self-checking bench for prog_mem_loader (default parameters).
//   The reference model is a plain word array. Each load is modelled as a
//   whole: the bytes are queued, and at ld_done the queue is cut into words.
//   Define PROG_MEM_PARITY_EN to include the parity-corruption sequence.
// ---------------------------------------------------------------------------
module tb_prog_mem_loader;

   localparam int PC_WIDTH = 8;
   localparam int IR_WIDTH = 16;
   localparam int CMD_CNT  = 64;
   localparam int NB       = IR_WIDTH / 8;

   logic                clk;
   logic                res;
   logic [PC_WIDTH-1:0] pc;
   logic                rd_en;
   logic [IR_WIDTH-1:0] ir;
   logic                ir_valid;
   logic                ld_start;
   logic [7:0]          ld_byte;
   logic                ld_valid;
   logic                ld_ready;
   logic                ld_done;
   logic                busy;
   logic                ld_err;
   logic                par_err;

   int checks   = 0;
   int failures = 0;

   logic [IR_WIDTH-1:0] model_mem [CMD_CNT];
   logic [IR_WIDTH-1:0] ir_exp;
   logic [7:0]          byte_q [$];
   bit                  err_exp;

   typedef struct {
      logic                rd;
      logic [PC_WIDTH-1:0] addr;
      logic [IR_WIDTH-1:0] ir;
      logic                valid;
   } vec_t;
   vec_t vecs [8];

   prog_mem_loader #(
      .PC_WIDTH (PC_WIDTH),
      .IR_WIDTH (IR_WIDTH),
      .CMD_CNT  (CMD_CNT)
   ) dut (
      .clk      (clk),
      .res      (res),
      .pc       (pc),
      .rd_en    (rd_en),
      .ir       (ir),
      .ir_valid (ir_valid),
      .ld_start (ld_start),
      .ld_byte  (ld_byte),
      .ld_valid (ld_valid),
      .ld_ready (ld_ready),
      .ld_done  (ld_done),
      .busy     (busy),
      .ld_err   (ld_err),
      .par_err  (par_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < CMD_CNT; i++) model_mem[i] = '0;
   endtask

   function automatic logic [IR_WIDTH-1:0] model_read(input logic [PC_WIDTH-1:0] a);
      return (int'(a) < CMD_CNT) ? model_mem[a] : '0;
   endfunction

   // The byte stream is cut into whole words, at most CMD_CNT of them.
   // Overflow bytes and a trailing partial word are errors.
   task automatic model_load(output bit err);
      int n;
      int nw;
      logic [IR_WIDTH-1:0] w;
      n  = byte_q.size();
      nw = n / NB;
      if (nw > CMD_CNT) nw = CMD_CNT;
      for (int i = 0; i < nw; i++) begin
         w = '0;
         for (int j = 0; j < NB; j++) w = (w << 8) | IR_WIDTH'(byte_q[i*NB + j]);
         model_mem[i] = w;
      end
      err = (n > CMD_CNT * NB) || (n % NB != 0);
   endtask

   task automatic do_read(input string name, input logic [PC_WIDTH-1:0] a);
      pc    = a;
      rd_en = 1'b1;
      tick();
      rd_en  = 1'b0;
      ir_exp = model_read(a);
      check({name, "_valid"}, ir_valid, 1'b1);
      check({name, "_ir"}, ir, ir_exp);
      check({name, "_par"}, par_err, 1'b0);
   endtask

   task automatic start_load();
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      byte_q.delete();
      check("load_ready", ld_ready, 1'b1);
      check("load_err_clr", ld_err, 1'b0);
   endtask

   // While loading, rd_en is held high; it must be ignored and ir must hold.
   task automatic send_byte(input logic [7:0] b, input logic done);
      byte_q.push_back(b);
      ld_byte  = b;
      ld_valid = 1'b1;
      ld_done  = done;
      rd_en    = 1'b1;
      pc       = PC_WIDTH'($urandom_range(0, CMD_CNT - 1));
      tick();
      ld_valid = 1'b0;
      ld_done  = 1'b0;
      rd_en    = 1'b0;
      check("load_ir_valid", ir_valid, 1'b0);
      check("load_ir_hold", ir, ir_exp);
   endtask

   task automatic end_load();
      ld_done = 1'b1;
      tick();
      ld_done = 1'b0;
   endtask

   // Counts cycles until busy falls. rd_en and ld_start stay high the whole
   // time and must be ignored.
   task automatic wait_clear();
      int  n;
      bit  saw_valid;
      n         = 0;
      saw_valid = 1'b0;
      rd_en     = 1'b1;
      ld_start  = 1'b1;
      pc        = '0;
      while (busy === 1'b1 && n < 200) begin
         tick();
         n++;
         if (ir_valid !== 1'b0) saw_valid = 1'b1;
      end
      rd_en    = 1'b0;
      ld_start = 1'b0;
      check("clear_cycles", n, CMD_CNT);
      check("clear_rd_ignored", saw_valid, 1'b0);
      check("clear_ld_ready", ld_ready, 1'b0);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_busy"}, busy, 1'b1);
      check({name, "_ir"}, ir, '0);
      check({name, "_ir_valid"}, ir_valid, 1'b0);
      check({name, "_ld_ready"}, ld_ready, 1'b0);
      check({name, "_ld_err"}, ld_err, 1'b0);
      check({name, "_par_err"}, par_err, 1'b0);
   endtask

   initial begin
      int  n;
      bit  dwl;
      bit  rd;
      res      = 1'b1;
      pc       = '0;
      rd_en    = 1'b0;
      ld_start = 1'b0;
      ld_byte  = '0;
      ld_valid = 1'b0;
      ld_done  = 1'b0;
      ir_exp   = '0;
      model_clear();

      // Reset state, then the CLEAR sweep and an all-zero memory.
      tick();
      tick();
      check_reset_outputs("reset");
      res = 1'b0;
      wait_clear();
      for (int a = 0; a < CMD_CNT; a++) do_read("blank", PC_WIDTH'(a));

      // Two-word load. A read issued with ld_start still completes.
      pc       = 8'd1;
      rd_en    = 1'b1;
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      rd_en    = 1'b0;
      byte_q.delete();
      ir_exp = '0;
      check("start_read_valid", ir_valid, 1'b1);
      check("start_read_ir", ir, 16'h0000);
      check("start_ld_ready", ld_ready, 1'b1);
      send_byte(8'h49, 1'b0);
      send_byte(8'h03, 1'b0);
      send_byte(8'h4A, 1'b0);
      send_byte(8'h14, 1'b0);
      end_load();
      model_load(err_exp);
      check("two_word_busy", busy, 1'b0);
      check("two_word_err", ld_err, 1'b0);
      check("ld_ready_run", ld_ready, 1'b0);

      // Reads after that load, driven from a fixed table.
      vecs[0] = '{1'b1, 8'd0,   16'h4903, 1'b1};
      vecs[1] = '{1'b1, 8'd1,   16'h4A14, 1'b1};
      vecs[2] = '{1'b0, 8'd1,   16'h4A14, 1'b0};
      vecs[3] = '{1'b1, 8'd2,   16'h0000, 1'b1};
      vecs[4] = '{1'b1, 8'd200, 16'h0000, 1'b1};
      vecs[5] = '{1'b1, 8'd64,  16'h0000, 1'b1};
      vecs[6] = '{1'b1, 8'd1,   16'h4A14, 1'b1};
      vecs[7] = '{1'b0, 8'd0,   16'h4A14, 1'b0};
      for (int i = 0; i < 8; i++) begin
         rd_en = vecs[i].rd;
         pc    = vecs[i].addr;
         tick();
         check($sformatf("vec%0d_ir", i), ir, vecs[i].ir);
         check($sformatf("vec%0d_valid", i), ir_valid, vecs[i].valid);
      end
      rd_en  = 1'b0;
      ir_exp = 16'h4A14;

      // ld_done in RUN is ignored.
      end_load();
      check("done_in_run_busy", busy, 1'b0);

      // Reset in the middle of a load (two words plus one byte).
      start_load();
      send_byte(8'hAA, 1'b0);
      send_byte(8'h55, 1'b0);
      send_byte(8'hC3, 1'b0);
      send_byte(8'h3C, 1'b0);
      send_byte(8'h77, 1'b0);
      res = 1'b1;
      #1;
      check_reset_outputs("mid_load_reset");
      tick();
      res    = 1'b0;
      ir_exp = '0;
      model_clear();
      wait_clear();
      for (int a = 0; a < CMD_CNT; a++) do_read("recleared", PC_WIDTH'(a));

      // Partial final word.
      start_load();
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      send_byte(8'h56, 1'b0);
      end_load();
      model_load(err_exp);
      check("partial_err", ld_err, 1'b1);
      do_read("partial_w0", 8'd0);
      check("partial_w0_const", ir, 16'h1234);
      do_read("partial_w1", 8'd1);
      check("partial_w1_const", ir, 16'h0000);
      start_load();
      end_load();
      model_load(err_exp);
      check("empty_load_err", ld_err, 1'b0);

      // Overflow: 130 bytes, the final data byte together with ld_done.
      start_load();
      for (int k = 0; k < 130; k++) send_byte(8'($urandom), 1'(k == 129));
      model_load(err_exp);
      check("overflow_err", ld_err, 1'b1);
      check("overflow_busy", busy, 1'b0);
      for (int a = 0; a < CMD_CNT; a++) do_read("overflow", PC_WIDTH'(a));
      do_read("out_of_range", 8'd200);

`ifdef PROG_MEM_PARITY_EN
      begin
         logic p;
         p = dut.mem[5][IR_WIDTH];
         force dut.mem[5][IR_WIDTH] = ~p;
         pc    = 8'd5;
         rd_en = 1'b1;
         tick();
         rd_en = 1'b0;
         check("parity_ir", ir, 16'h0000);
         check("parity_err", par_err, 1'b1);
         check("parity_valid", ir_valid, 1'b1);
         release dut.mem[5][IR_WIDTH];
         ir_exp = '0;
      end
`endif

      // Randomized loads, each followed by random reads.
      for (int it = 0; it < 6; it++) begin
         n   = (it == 1) ? CMD_CNT * NB : $urandom_range(0, 140);
         dwl = 1'($urandom_range(0, 1));
         start_load();
         for (int k = 0; k < n; k++) begin
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
               rd_en = 1'b1;
               pc    = 8'($urandom);
               tick();
               rd_en = 1'b0;
               check("rand_gap_valid", ir_valid, 1'b0);
            end
            send_byte(8'($urandom), 1'(dwl && (k == n - 1)));
         end
         if (!(dwl && n > 0)) end_load();
         model_load(err_exp);
         check("rand_load_err", ld_err, err_exp);
         check("rand_load_busy", busy, 1'b0);
         for (int c = 0; c < 40; c++) begin
            rd       = 1'($urandom_range(0, 1));
            rd_en    = rd;
            pc       = $urandom_range(0, 1) ? PC_WIDTH'($urandom_range(0, CMD_CNT - 1)) : 8'($urandom);
            ld_done  = ($urandom_range(0, 3) == 0);
            ld_valid = 1'($urandom_range(0, 1));
            tick();
            if (rd) ir_exp = model_read(pc);
            check("rand_ir", ir, ir_exp);
            check("rand_valid", ir_valid, rd);
            check("rand_busy", busy, 1'b0);
            check("rand_ld_ready", ld_ready, 1'b0);
         end
         rd_en    = 1'b0;
         ld_done  = 1'b0;
         ld_valid = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
